fwd_sel_unit: RTL and testbench

- Generates the registered 2-bit select codes for the two 64-bit 4:1 operand muxes at the front of the EX stage of the pipelined CPU.
- Keeps its own shadow pipeline of destination-register info for the EX and MEM stages.
- Detects EX/MEM and MEM/WB forwarding and load-use hazards, and drives the ID stall.
- Counts stall cycles for performance visibility.

---
 rtl/fwd_sel_unit.sv | 153 +++++++++++++++
 tb/tb_fwd_sel_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: forwarding-select and load-use stall generator for the EX stage.
//
// Keeps a shadow copy of the destination-register info for the instructions in EX
// and MEM, and produces the registered 2-bit operand mux selects for the instruction
// entering EX:
//   00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback data, 11 immediate (B only).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   id_valid     ID holds a real instruction
//   id_rn/id_rm  operand A / operand B source registers
//   id_rd        destination register
//   id_regwrite  instruction writes id_rd
//   id_memread   instruction is a load
//   id_use_imm   operand B is the immediate
//   flush        kill the ID instruction
//   stall_id     hold PC and IF/ID this cycle (combinational)
//   ex_valid     EX holds a real instruction (registered)
//   ex_sel_a/b   operand mux selects (registered)
//   stall_cnt    saturating count of stall cycles
module fwd_sel_unit #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_use_imm,
    input  logic             flush,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [1:0]       ex_sel_a,
    output logic [1:0]       ex_sel_b,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [REG_W-1:0] ZeroIdx = REG_W'(ZERO_REG);

    // EX shadow stage
    logic             ex_valid_q, ex_valid_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_regwrite_q, ex_regwrite_d;
    logic             ex_memread_q, ex_memread_d;
    // MEM shadow stage
    logic             mem_valid_q, mem_valid_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    logic             mem_regwrite_q, mem_regwrite_d;
    // Registered selects and counter
    logic [1:0]       ex_sel_a_q, ex_sel_a_d;
    logic [1:0]       ex_sel_b_q, ex_sel_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Forward source for one operand; EX is checked first since it is the newest producer.
    function automatic logic [1:0] fwd_src(input logic [REG_W-1:0] src,
                                           input logic             exv,
                                           input logic             exw,
                                           input logic [REG_W-1:0] exd,
                                           input logic             memv,
                                           input logic             memw,
                                           input logic [REG_W-1:0] memd);
        logic [1:0] sel;
        sel = 2'b00;
        if (src == ZeroIdx) begin
            sel = 2'b00;
        end else if (exv && exw && (exd == src)) begin
            sel = 2'b01;
        end else if (memv && memw && (memd == src)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    // Load in EX whose result the ID instruction needs: one bubble is unavoidable.
    // flush kills the ID instruction, so it also suppresses the stall.
    always_comb begin
        stall_id = 1'b0;
        if (id_valid && !flush && ex_valid_q && ex_memread_q && ex_regwrite_q &&
            (ex_rd_q != ZeroIdx) &&
            ((ex_rd_q == id_rn) || ((ex_rd_q == id_rm) && !id_use_imm))) begin
            stall_id = 1'b1;
        end
    end

    always_comb begin
        // MEM always takes whatever EX held; only ID can be held back.
        mem_valid_d    = ex_valid_q;
        mem_rd_d       = ex_rd_q;
        mem_regwrite_d = ex_regwrite_q;

        ex_valid_d    = 1'b0;
        ex_rd_d       = '0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        ex_sel_a_d    = 2'b00;
        ex_sel_b_d    = 2'b00;

        if (!(flush || stall_id)) begin
            ex_valid_d    = id_valid;
            ex_rd_d       = id_rd;
            ex_regwrite_d = id_regwrite & id_valid;
            ex_memread_d  = id_memread & id_valid;
            ex_sel_a_d    = fwd_src(id_rn, ex_valid_q, ex_regwrite_q, ex_rd_q,
                                    mem_valid_q, mem_regwrite_q, mem_rd_q);
            ex_sel_b_d    = id_use_imm ? 2'b11 :
                            fwd_src(id_rm, ex_valid_q, ex_regwrite_q, ex_rd_q,
                                    mem_valid_q, mem_regwrite_q, mem_rd_q);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_id && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            ex_sel_a_q     <= 2'b00;
            ex_sel_b_q     <= 2'b00;
            stall_cnt_q    <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            mem_valid_q    <= mem_valid_d;
            mem_rd_q       <= mem_rd_d;
            mem_regwrite_q <= mem_regwrite_d;
            ex_sel_a_q     <= ex_sel_a_d;
            ex_sel_b_q     <= ex_sel_b_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_sel_a  = ex_sel_a_q;
    assign ex_sel_b  = ex_sel_b_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Testbench for fwd_sel_unit: directed scenarios plus random traffic, checked against
// a model that tracks the last two instructions issued into EX by age.
// A second instance with an 8-bit counter exercises counter saturation in few cycles.
module tb_fwd_sel_unit;

    typedef struct packed {
        logic       v;
        logic [4:0] rn;
        logic [4:0] rm;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       imm;
    } id_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } slot_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_regwrite, id_memread, id_use_imm, flush;
    logic [4:0] id_rn, id_rm, id_rd;

    logic        stall_id, ex_valid;
    logic [1:0]  ex_sel_a, ex_sel_b;
    logic [15:0] stall_cnt;

    logic        n_stall_id, n_ex_valid;
    logic [1:0]  n_ex_sel_a, n_ex_sel_b;
    logic [7:0]  n_stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: age[0] = instruction now in EX, age[1] = in MEM.
    slot_t      age [2];
    int         m_stalls;
    logic       m_ex_v;
    logic       m_sel_known;
    logic [1:0] m_sel_a, m_sel_b;

    always #5 clk = ~clk;

    fwd_sel_unit u_dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_use_imm  (id_use_imm),
        .flush       (flush),
        .stall_id    (stall_id),
        .ex_valid    (ex_valid),
        .ex_sel_a    (ex_sel_a),
        .ex_sel_b    (ex_sel_b),
        .stall_cnt   (stall_cnt)
    );

    fwd_sel_unit #(.CNT_W(8)) u_dut_n (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_use_imm  (id_use_imm),
        .flush       (flush),
        .stall_id    (n_stall_id),
        .ex_valid    (n_ex_valid),
        .ex_sel_a    (n_ex_sel_a),
        .ex_sel_b    (n_ex_sel_b),
        .stall_cnt   (n_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic id_t mk(input logic v, input int rn, input int rm, input int rd,
                               input logic rw, input logic mr, input logic imm);
        id_t i;
        i.v = v; i.rn = 5'(rn); i.rm = 5'(rm); i.rd = 5'(rd);
        i.rw = rw; i.mr = mr; i.imm = imm;
        return i;
    endfunction

    // Newest earlier writer of src wins; XZR is never forwarded.
    function automatic logic [1:0] model_src(input logic [4:0] src);
        if (src == 5'd31) return 2'b00;
        for (int d = 0; d < 2; d++) begin
            if (age[d].v && age[d].rw && age[d].rd == src) return (d == 0) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic logic model_stall(input id_t i, input logic fl);
        if (!i.v || fl) return 1'b0;
        if (!(age[0].v && age[0].mr && age[0].rw) || age[0].rd == 5'd31) return 1'b0;
        return (age[0].rd == i.rn) || (age[0].rd == i.rm && !i.imm);
    endfunction

    // One clock: drive at negedge, check stall before the edge, check registered after.
    task automatic step(input id_t i, input logic fl, input logic rst_n, output logic st);
        logic  exp_st;
        slot_t nxt;
        @(negedge clk);
        reset = rst_n; flush = fl;
        id_valid = i.v; id_rn = i.rn; id_rm = i.rm; id_rd = i.rd;
        id_regwrite = i.rw; id_memread = i.mr; id_use_imm = i.imm;
        #1;
        exp_st = model_stall(i, fl);
        check("stall_id", {31'd0, stall_id}, {31'd0, exp_st});
        check("stall_id_n", {31'd0, n_stall_id}, {31'd0, exp_st});
        st = stall_id;
        @(posedge clk);
        if (!rst_n) begin
            age[0] = '0; age[1] = '0;
            m_stalls = 0; m_ex_v = 1'b0; m_sel_known = 1'b1;
            m_sel_a = 2'b00; m_sel_b = 2'b00;
        end else begin
            if (exp_st) m_stalls++;
            if (fl || exp_st) begin
                nxt = '0;
                m_sel_a = 2'b00; m_sel_b = 2'b00; m_sel_known = 1'b1;
            end else begin
                nxt.v = i.v; nxt.rd = i.rd; nxt.rw = i.rw & i.v; nxt.mr = i.mr & i.v;
                m_sel_a = model_src(i.rn);
                m_sel_b = i.imm ? 2'b11 : model_src(i.rm);
                m_sel_known = i.v;
            end
            age[1] = age[0];
            age[0] = nxt;
            m_ex_v = nxt.v;
        end
        #1;
        check("ex_valid", {31'd0, ex_valid}, {31'd0, m_ex_v});
        if (m_sel_known) begin
            check("ex_sel_a", {30'd0, ex_sel_a}, {30'd0, m_sel_a});
            check("ex_sel_b", {30'd0, ex_sel_b}, {30'd0, m_sel_b});
            check("ex_sel_a_n", {30'd0, n_ex_sel_a}, {30'd0, m_sel_a});
        end
        check("stall_cnt", {16'd0, stall_cnt}, (m_stalls > 65535) ? 32'd65535 : m_stalls);
        check("stall_cnt_n", {24'd0, n_stall_cnt}, (m_stalls > 255) ? 32'd255 : m_stalls);
    endtask

    function automatic int rreg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 31 : r;
    endfunction

    function automatic id_t rand_id();
        return mk(1'($urandom_range(0, 7) != 0), rreg(), rreg(), rreg(),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 3) == 0));
    endfunction

    initial begin
        logic st;
        id_t  nop, ldr5, add5, cur;
        nop  = mk(0, 0, 0, 0, 0, 0, 0);
        ldr5 = mk(1, 9, 10, 5, 1, 1, 0);
        add5 = mk(1, 5, 6, 7, 1, 0, 0);
        age[0] = '0; age[1] = '0;
        m_stalls = 0; m_ex_v = 1'b0; m_sel_known = 1'b0;
        m_sel_a = 2'b00; m_sel_b = 2'b00;
        reset = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_rn = '0; id_rm = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; id_use_imm = 1'b0;

        // Reset with random ID inputs
        step(rand_id(), 1'b0, 1'b0, st);
        step(rand_id(), 1'b0, 1'b0, st);
        check("rst_sel_a", {30'd0, ex_sel_a}, 32'd0);
        check("rst_sel_b", {30'd0, ex_sel_b}, 32'd0);
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_stall", {31'd0, stall_id}, 32'd0);

        // EX/MEM forward, then MEM/WB forward across one unrelated instruction
        step(mk(1, 2, 3, 1, 1, 0, 0), 1'b0, 1'b1, st);
        step(mk(1, 1, 2, 4, 1, 0, 0), 1'b0, 1'b1, st);
        check("exmem_a", {30'd0, ex_sel_a}, 32'd1);
        check("exmem_b", {30'd0, ex_sel_b}, 32'd0);
        step(mk(1, 2, 3, 1, 1, 0, 0), 1'b0, 1'b1, st);
        step(mk(1, 6, 7, 8, 1, 0, 0), 1'b0, 1'b1, st);
        step(mk(1, 1, 2, 4, 1, 0, 0), 1'b0, 1'b1, st);
        check("memwb_a", {30'd0, ex_sel_a}, 32'd2);

        // Newest producer wins; XZR never forwards
        step(mk(1, 0, 0, 3, 1, 0, 0), 1'b0, 1'b1, st);
        step(mk(1, 0, 0, 3, 1, 0, 0), 1'b0, 1'b1, st);
        step(mk(1, 3, 0, 4, 1, 0, 0), 1'b0, 1'b1, st);
        check("prio_a", {30'd0, ex_sel_a}, 32'd1);
        step(mk(1, 0, 0, 31, 1, 0, 0), 1'b0, 1'b1, st);
        step(mk(1, 31, 31, 4, 1, 0, 0), 1'b0, 1'b1, st);
        check("xzr_a", {30'd0, ex_sel_a}, 32'd0);
        check("xzr_b", {30'd0, ex_sel_b}, 32'd0);

        // Load-use: one stall, one bubble, then consumer reads WB data
        step(nop, 1'b0, 1'b1, st);
        step(ldr5, 1'b0, 1'b1, st);
        step(add5, 1'b0, 1'b1, st);
        check("lu_stall", {31'd0, st}, 32'd1);
        check("lu_cnt", {16'd0, stall_cnt}, 32'd1);
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        step(add5, 1'b0, 1'b1, st);
        check("lu_once", {31'd0, st}, 32'd0);
        check("lu_valid", {31'd0, ex_valid}, 32'd1);
        check("lu_sel_a", {30'd0, ex_sel_a}, 32'd2);

        // Immediate operand hides the dependency on rm
        step(ldr5, 1'b0, 1'b1, st);
        step(mk(1, 6, 5, 7, 1, 0, 1), 1'b0, 1'b1, st);
        check("imm_stall", {31'd0, st}, 32'd0);
        check("imm_sel_b", {30'd0, ex_sel_b}, 32'd3);

        // Flush beats stall
        step(ldr5, 1'b0, 1'b1, st);
        step(add5, 1'b1, 1'b1, st);
        check("flush_stall", {31'd0, st}, 32'd0);
        check("flush_bubble", {31'd0, ex_valid}, 32'd0);
        check("flush_cnt", {16'd0, stall_cnt}, 32'd1);

        // Reset in the middle of a stall
        step(ldr5, 1'b0, 1'b1, st);
        step(add5, 1'b0, 1'b0, st);
        check("midrst_cnt", {16'd0, stall_cnt}, 32'd0);
        step(add5, 1'b0, 1'b1, st);
        check("midrst_stall", {31'd0, st}, 32'd0);
        check("midrst_sel_a", {30'd0, ex_sel_a}, 32'd0);

        // Saturation: chained dependent loads give a stall every other cycle
        step(ldr5, 1'b0, 1'b1, st);
        for (int k = 0; k < 259; k++) begin
            step(mk(1, 5, 0, 5, 1, 1, 0), 1'b0, 1'b1, st);
            step(mk(1, 5, 0, 5, 1, 1, 0), 1'b0, 1'b1, st);
        end
        check("sat_n", {24'd0, n_stall_cnt}, 32'd255);
        check("sat_wide", {16'd0, stall_cnt}, 32'd259);

        // Random traffic; a stalled instruction is re-presented until it issues
        cur = rand_id();
        for (int k = 0; k < 3000; k++) begin
            step(cur, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 99) != 0), st);
            if (!st || !reset) cur = rand_id();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
